// File: rtl/systolic_job_sequencer.sv
// Command queue plus FEED/DRAIN/WRITE sequencing for one 4x4 systolic array.
// Every output is registered one cycle behind the state/count that produces it.
module systolic_job_sequencer #(
    parameter int ADDR_W     = 7,
    parameter int K_W        = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [K_W-1:0]        i_cmd_k,
    input  logic [ADDR_W-1:0]     i_cmd_base,
    input  logic                  i_abort,
    output logic                  o_mem_r_en,
    output logic [4*ADDR_W-1:0]   o_row_addr,
    output logic [4*ADDR_W-1:0]   o_col_addr,
    output logic [6:0]            o_pe_en,
    output logic                  o_pe_clr,
    output logic                  o_c_wr_en,
    output logic                  o_busy,
    output logic                  o_job_done,
    output logic                  o_err_cmd
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = 6;
    localparam int WIDE_W = ADDR_W + K_W + 3;

    localparam logic [ADDR_W-1:0] IDLE_ADDR  = '1;
    localparam logic [PTR_W:0]    PTR_ONE    = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DRAIN_LEN  = CNT_W'(6);
    localparam logic [WIDE_W-1:0] ADDR_LIMIT = WIDE_W'((1 << ADDR_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_WRITE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_k_cnt;
    logic [K_W-1:0]    r_job_k;
    logic [ADDR_W-1:0] r_job_base;

    logic [K_W-1:0]    r_q_k    [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_q_base [FIFO_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [PTR_W:0]    w_wr_ptr_nxt;
    logic [PTR_W:0]    w_rd_ptr_nxt;
    logic              w_empty;
    logic              w_full_nxt;

    logic              w_accept;
    logic              w_cmd_ok;
    logic              w_push;
    logic              w_pop;
    logic [WIDE_W-1:0] w_cmd_end;

    logic [6:0]          w_pe_en_nxt;
    logic                w_pe_clr_nxt;
    logic                w_mem_r_en_nxt;
    logic                w_capture_nxt;
    logic [4*ADDR_W-1:0] w_lane_addr_nxt;
    logic [ADDR_W-1:0]   w_lane;

    logic                r_cmd_ready;
    logic [6:0]          r_pe_en;
    logic                r_pe_clr;
    logic                r_mem_r_en;
    logic                r_capture;
    logic [4*ADDR_W-1:0] r_lane_addr;
    logic                r_busy;
    logic                r_err_cmd;

    // A command is legal when K is nonzero and its last operand (base+4K-1) stays below the idle address.
    assign w_cmd_end = WIDE_W'(i_cmd_base) + (WIDE_W'(i_cmd_k) << 2);
    assign w_cmd_ok  = (i_cmd_k != '0) && (w_cmd_end <= ADDR_LIMIT);
    assign w_accept  = i_cmd_valid && r_cmd_ready;
    assign w_push    = w_accept && w_cmd_ok && !i_abort;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_pop     = (r_state == S_IDLE) && !w_empty && !i_abort;
    assign w_k_cnt   = CNT_W'(r_job_k);

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (i_abort) begin
            w_rd_ptr_nxt = r_wr_ptr;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign w_full_nxt = (w_wr_ptr_nxt[PTR_W] != w_rd_ptr_nxt[PTR_W]) &&
                        (w_wr_ptr_nxt[PTR_W-1:0] == w_rd_ptr_nxt[PTR_W-1:0]);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_k[r_wr_ptr[PTR_W-1:0]]    <= i_cmd_k;
            r_q_base[r_wr_ptr[PTR_W-1:0]] <= i_cmd_base;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    if (!w_empty) begin
                        w_state_nxt = S_FEED;
                    end
                end
                S_FEED: begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (r_cnt == w_k_cnt - CNT_ONE) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (r_cnt == w_k_cnt + DRAIN_LEN) begin
                        w_state_nxt = S_WRITE;
                    end
                end
                S_WRITE: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_job_k    <= '0;
            r_job_base <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_pop) begin
                r_job_k    <= r_q_k[r_rd_ptr[PTR_W-1:0]];
                r_job_base <= r_q_base[r_rd_ptr[PTR_W-1:0]];
            end
        end
    end

    // WRITE still captures under abort; otherwise abort forces the idle output pattern.
    always_comb begin
        w_pe_en_nxt     = '0;
        w_pe_clr_nxt    = 1'b1;
        w_mem_r_en_nxt  = 1'b0;
        w_capture_nxt   = 1'b0;
        w_lane_addr_nxt = {4{IDLE_ADDR}};
        w_lane          = '0;
        if (r_state == S_WRITE) begin
            w_pe_clr_nxt  = 1'b0;
            w_capture_nxt = 1'b1;
        end else if (!i_abort && (r_state == S_FEED || r_state == S_DRAIN)) begin
            w_pe_clr_nxt = 1'b0;
            for (int j = 0; j < 7; j++) begin
                w_pe_en_nxt[j] = (r_cnt >= CNT_W'(j + 1)) && (r_cnt <= CNT_W'(j) + w_k_cnt);
            end
            if (r_state == S_FEED) begin
                w_mem_r_en_nxt = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    w_lane = r_job_base + ADDR_W'(r_cnt) + ADDR_W'(i) * ADDR_W'(r_job_k);
                    w_lane_addr_nxt[i*ADDR_W +: ADDR_W] = w_lane;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmd_ready <= 1'b1;
            r_pe_en     <= '0;
            r_pe_clr    <= 1'b1;
            r_mem_r_en  <= 1'b0;
            r_capture   <= 1'b0;
            r_lane_addr <= {4{IDLE_ADDR}};
            r_busy      <= 1'b0;
            r_err_cmd   <= 1'b0;
        end else begin
            r_cmd_ready <= !w_full_nxt;
            r_pe_en     <= w_pe_en_nxt;
            r_pe_clr    <= w_pe_clr_nxt;
            r_mem_r_en  <= w_mem_r_en_nxt;
            r_capture   <= w_capture_nxt;
            r_lane_addr <= w_lane_addr_nxt;
            r_busy      <= (w_state_nxt != S_IDLE) || (w_wr_ptr_nxt != w_rd_ptr_nxt);
            r_err_cmd   <= w_accept && !w_cmd_ok && !i_abort;
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_mem_r_en  = r_mem_r_en;
    assign o_row_addr  = r_lane_addr;
    assign o_col_addr  = r_lane_addr;
    assign o_pe_en     = r_pe_en;
    assign o_pe_clr    = r_pe_clr;
    assign o_c_wr_en   = r_capture;
    assign o_job_done  = r_capture;
    assign o_busy      = r_busy;
    assign o_err_cmd   = r_err_cmd;

endmodule
